vga_board_renderer: RTL and testbench

Pixel-rendering stage that sits directly downstream of the 800x600 VGA timing generator. It consumes the pixel coordinates, display-enable and sync signals, and draws the MasterMind board as a grid of coloured peg cells. The board is 10 rows x 8 columns: columns 0-3 are guess pegs and columns 4-7 are hint pegs. Board contents are written by game logic into a shadow store and committed to the displayed store once per frame, so partial updates never tear.

---
 rtl/vga_board_renderer.sv | 142 ++++++++++++++
 tb/tb_vga_board_renderer.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_board_renderer.sv
// MasterMind board renderer behind the 800x600 timing generator; optional CURSOR_HIGHLIGHT_EN lights the cursor row's gaps.
// Latency: 2 clk from pix_x/pix_y/pix_de/syncs to RGB/HSYNC/VSYNC; board writes appear after the next vsync rising edge.
// Backpressure: none, free-running pixel stream; writes and clr are accepted every cycle.
module vga_board_renderer #(
    parameter logic [10:0] BOARD_X    = 11'd272,
    parameter logic [9:0]  BOARD_Y    = 10'd140,
    parameter logic [2:0]  GRID_COLOR = 3'b001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [10:0] pix_x,
    input  logic [9:0]  pix_y,
    input  logic        pix_de,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        wr_en,
    input  logic [3:0]  wr_row,
    input  logic [2:0]  wr_col,
    input  logic [2:0]  wr_data,
    input  logic        clr,
    input  logic [3:0]  cursor_row,
    output logic [2:0]  RGB,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        commit
);

    logic [2:0] shadow [10][8];
    logic [2:0] active [10][8];

    // Stage-1 registers; vs_d1 doubles as the vsync edge detector.
    logic       de_d, hs_d, vs_d1, in_board_d, cur_hit_d;
    logic [3:0] row_d;
    logic [2:0] col_d;
    logic [4:0] offx_d, offy_d;

    // Borrow into the upper bits flags coordinates left of / above the board.
    logic [11:0] dx;
    logic [10:0] dy;
    assign dx = {1'b0, pix_x} - {1'b0, BOARD_X};
    assign dy = {1'b0, pix_y} - {1'b0, BOARD_Y};

    logic vs_rise;
    assign vs_rise = vsync_in & ~vs_d1;

    always_ff @(posedge clk) begin
        if (rst) begin
            commit <= 1'b0;
            for (int r = 0; r < 10; r++) begin
                for (int c = 0; c < 8; c++) begin
                    shadow[r][c] <= 3'd0;
                    active[r][c] <= 3'd0;
                end
            end
        end else begin
            commit <= vs_rise;
            if (vs_rise) begin
                for (int r = 0; r < 10; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        active[r][c] <= shadow[r][c];
                    end
                end
            end
            if (clr) begin
                for (int r = 0; r < 10; r++) begin
                    for (int c = 0; c < 8; c++) begin
                        shadow[r][c] <= 3'd0;
                    end
                end
            end else if (wr_en && wr_row < 4'd10) begin
                shadow[wr_row][wr_col] <= wr_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            de_d       <= 1'b0;
            hs_d       <= 1'b0;
            vs_d1      <= 1'b0;
            in_board_d <= 1'b0;
            row_d      <= 4'd0;
            col_d      <= 3'd0;
            offx_d     <= 5'd0;
            offy_d     <= 5'd0;
        end else begin
            de_d       <= pix_de;
            hs_d       <= hsync_in;
            vs_d1      <= vsync_in;
            in_board_d <= pix_de && (dx[11:8] == 4'd0) && (dy[10:6] < 5'd5);
            row_d      <= dy[8:5];
            col_d      <= dx[7:5];
            offx_d     <= dx[4:0];
            offy_d     <= dy[4:0];
        end
    end

`ifdef CURSOR_HIGHLIGHT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cur_hit_d <= 1'b0;
        end else begin
            cur_hit_d <= (cursor_row < 4'd10) && (cursor_row == dy[8:5]);
        end
    end
`else
    logic unused_cursor;
    assign unused_cursor = ^cursor_row;
    assign cur_hit_d     = 1'b0;
`endif

    logic       peg;
    logic [2:0] pix_color;
    assign peg = (offx_d >= 5'd4) && (offx_d <= 5'd27) &&
                 (offy_d >= 5'd4) && (offy_d <= 5'd27);

    always_comb begin
        pix_color = 3'd0;
        if (de_d && in_board_d) begin
            if (peg) begin
                pix_color = active[row_d][col_d];
            end else if (cur_hit_d) begin
                pix_color = 3'b111;
            end else begin
                pix_color = GRID_COLOR;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            RGB   <= 3'd0;
            HSYNC <= 1'b0;
            VSYNC <= 1'b0;
        end else begin
            RGB   <= pix_color;
            HSYNC <= hs_d;
            VSYNC <= vs_d1;
        end
    end

endmodule

// File: tb/tb_vga_board_renderer.sv
// Directed bench for vga_board_renderer: reset, write/commit, collisions, boundaries, cursor row.
module tb_vga_board_renderer;

    localparam int BX = 272;
    localparam int BY = 140;
    localparam logic [2:0] GRID = 3'b001;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] pix_x;
    logic [9:0]  pix_y;
    logic        pix_de, hsync_in, vsync_in;
    logic        wr_en, clr;
    logic [3:0]  wr_row, cursor_row;
    logic [2:0]  wr_col, wr_data;
    logic [2:0]  RGB;
    logic        HSYNC, VSYNC, commit;

    int vectors = 0;
    int miscompares = 0;

    vga_board_renderer dut (
        .clk(clk), .rst(rst), .pix_x(pix_x), .pix_y(pix_y), .pix_de(pix_de),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_en(wr_en), .wr_row(wr_row),
        .wr_col(wr_col), .wr_data(wr_data), .clr(clr), .cursor_row(cursor_row),
        .RGB(RGB), .HSYNC(HSYNC), .VSYNC(VSYNC), .commit(commit)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic render(input int x, input int y, input logic de);
        pix_x  = 11'(x);
        pix_y  = 10'(y);
        pix_de = de;
        tick();
        tick();
    endtask

    task automatic write_cell(input logic [3:0] r, input logic [2:0] c, input logic [2:0] d);
        wr_en = 1'b1; wr_row = r; wr_col = c; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic pulse_vsync(output logic c_on, output logic c_off);
        vsync_in = 1'b1;
        tick();
        c_on = commit;
        vsync_in = 1'b0;
        tick();
        c_off = commit;
    endtask

    task automatic test_reset();
        logic [7:0] pat;
        pat = 8'b1011_0010;
        rst = 1'b1; pix_x = 11'(BX + 16); pix_y = 10'(BY + 16); pix_de = 1'b1;
        hsync_in = 1'b1; vsync_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if ({RGB, HSYNC, VSYNC, commit} !== 6'd0) begin
                miscompares++;
                $display("FAIL reset_outputs cycle %0d: RGB=%0d HSYNC=%0b VSYNC=%0b commit=%0b, required all 0",
                         i, RGB, HSYNC, VSYNC, commit);
            end
        end
        rst = 1'b0;
        tick();
        vectors++;
        if (commit !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_commit: commit=%0b, required 1", commit);
        end
        vsync_in = 1'b0;
        tick();
        vectors++;
        if (commit !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_commit_width: commit=%0b, required 0", commit);
        end
        for (int i = 0; i < 8; i++) begin
            hsync_in = pat[i];
            tick();
            if (i >= 1) begin
                vectors++;
                if (HSYNC !== pat[i-1]) begin
                    miscompares++;
                    $display("FAIL hsync_delay step %0d: HSYNC=%0b, required %0b", i, HSYNC, pat[i-1]);
                end
            end
        end
        hsync_in = 1'b0;
    endtask

    task automatic test_write_commit();
        logic c_on, c_off;
        write_cell(4'd2, 3'd1, 3'b101);
        pulse_vsync(c_on, c_off);
        vectors++;
        if (c_on !== 1'b1 || c_off !== 1'b0) begin
            miscompares++;
            $display("FAIL commit_pulse: got %0b then %0b, required 1 then 0", c_on, c_off);
        end
        render(BX + 48, BY + 80, 1'b1);
        vectors++;
        if (RGB !== 3'd5) begin
            miscompares++;
            $display("FAIL peg_r2c1: RGB=%0d, required 5", RGB);
        end
        render(BX + 32, BY + 64, 1'b1);
        vectors++;
        if (RGB !== GRID) begin
            miscompares++;
            $display("FAIL gap_r2c1: RGB=%0d, required %0d", RGB, GRID);
        end
    endtask

    task automatic test_no_commit();
        logic c_on, c_off;
        write_cell(4'd0, 3'd0, 3'b010);
        render(BX + 16, BY + 16, 1'b1);
        vectors++;
        if (RGB !== 3'd0) begin
            miscompares++;
            $display("FAIL no_vsync_hold: RGB=%0d, required 0", RGB);
        end
        pulse_vsync(c_on, c_off);
        render(BX + 16, BY + 16, 1'b1);
        vectors++;
        if (RGB !== 3'd2) begin
            miscompares++;
            $display("FAIL after_vsync_r0c0: RGB=%0d, required 2", RGB);
        end
    endtask

    task automatic test_collision();
        logic c_on, c_off;
        wr_en = 1'b1; wr_row = 4'd9; wr_col = 3'd7; wr_data = 3'b110;
        vsync_in = 1'b1;
        tick();
        c_on = commit;
        wr_en = 1'b0; vsync_in = 1'b0;
        tick();
        vectors++;
        if (c_on !== 1'b1) begin
            miscompares++;
            $display("FAIL collision_commit: commit=%0b, required 1", c_on);
        end
        render(BX + 240, BY + 304, 1'b1);
        vectors++;
        if (RGB !== 3'd0) begin
            miscompares++;
            $display("FAIL collision_hidden: RGB=%0d, required 0", RGB);
        end
        pulse_vsync(c_on, c_off);
        render(BX + 240, BY + 304, 1'b1);
        vectors++;
        if (RGB !== 3'd6) begin
            miscompares++;
            $display("FAIL collision_next_frame: RGB=%0d, required 6", RGB);
        end
        clr = 1'b1; wr_en = 1'b1; wr_row = 4'd3; wr_col = 3'd3; wr_data = 3'b111;
        tick();
        clr = 1'b0; wr_en = 1'b0;
        pulse_vsync(c_on, c_off);
        render(BX + 112, BY + 112, 1'b1);
        vectors++;
        if (RGB !== 3'd0) begin
            miscompares++;
            $display("FAIL clr_beats_write: RGB=%0d, required 0", RGB);
        end
        render(BX + 48, BY + 80, 1'b1);
        vectors++;
        if (RGB !== 3'd0) begin
            miscompares++;
            $display("FAIL clr_wipes_r2c1: RGB=%0d, required 0", RGB);
        end
    endtask

    task automatic test_invalid();
        logic c_on, c_off;
        write_cell(4'd12, 3'd1, 3'b111);
        pulse_vsync(c_on, c_off);
        render(BX + 48, BY + 80, 1'b1);
        vectors++;
        if (RGB !== 3'd0) begin
            miscompares++;
            $display("FAIL bad_row_r2: RGB=%0d, required 0", RGB);
        end
        render(BX + 48, BY + 144, 1'b1);
        vectors++;
        if (RGB !== 3'd0) begin
            miscompares++;
            $display("FAIL bad_row_r4: RGB=%0d, required 0", RGB);
        end
        render(BX + 240, BY + 304, 1'b0);
        vectors++;
        if (RGB !== 3'd0) begin
            miscompares++;
            $display("FAIL de_low_in_board: RGB=%0d, required 0", RGB);
        end
    endtask

    task automatic test_edges();
        logic c_on, c_off;
        int xs [10] = '{BX+255, BX+256, BX-1, BX+16,  BX+16,  BX+16, BX+4, BX+27, BX+3,  BX+28};
        int ys [10] = '{BY+16,  BY+16,  BY+16, BY+319, BY+320, BY-1, BY+4, BY+27, BY+16, BY+16};
        logic [2:0] exp [10] = '{GRID, 3'd0, 3'd0, GRID, 3'd0, 3'd0, 3'd3, 3'd3, GRID, GRID};
        write_cell(4'd0, 3'd0, 3'b011);
        pulse_vsync(c_on, c_off);
        for (int i = 0; i < 10; i++) begin
            render(xs[i], ys[i], 1'b1);
            vectors++;
            if (RGB !== exp[i]) begin
                miscompares++;
                $display("FAIL edge_%0d (x=%0d y=%0d): RGB=%0d, required %0d", i, xs[i], ys[i], RGB, exp[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int xs [4] = '{BX+254, BX+255, BX+256, BX+257};
        logic [2:0] exp [4] = '{GRID, GRID, 3'd0, 3'd0};
        logic [3:0] hs;
        hs = 4'b0101;
        pix_y = 10'(BY + 16);
        pix_de = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) begin
                pix_x = 11'(xs[i]);
                hsync_in = hs[i];
            end
            tick();
            if (i >= 1 && i <= 4) begin
                vectors++;
                if (RGB !== exp[i-1] || HSYNC !== hs[i-1]) begin
                    miscompares++;
                    $display("FAIL stream_%0d: RGB=%0d HSYNC=%0b, required RGB=%0d HSYNC=%0b",
                             i - 1, RGB, HSYNC, exp[i-1], hs[i-1]);
                end
            end
        end
        hsync_in = 1'b0;
    endtask

    task automatic test_cursor();
        cursor_row = 4'd4;
`ifdef CURSOR_HIGHLIGHT_EN
        render(BX + 1, BY + 129, 1'b1);
        vectors++;
        if (RGB !== 3'b111) begin
            miscompares++;
            $display("FAIL cursor_gap_row4: RGB=%0d, required 7", RGB);
        end
        render(BX + 1, BY + 97, 1'b1);
        vectors++;
        if (RGB !== GRID) begin
            miscompares++;
            $display("FAIL cursor_gap_row3: RGB=%0d, required %0d", RGB, GRID);
        end
        render(BX + 16, BY + 144, 1'b1);
        vectors++;
        if (RGB !== 3'd0) begin
            miscompares++;
            $display("FAIL cursor_peg_row4: RGB=%0d, required 0", RGB);
        end
`else
        render(BX + 1, BY + 129, 1'b1);
        vectors++;
        if (RGB !== GRID) begin
            miscompares++;
            $display("FAIL cursor_ignored: RGB=%0d, required %0d", RGB, GRID);
        end
`endif
        cursor_row = 4'd15;
    endtask

    initial begin
        rst = 1'b1; pix_x = '0; pix_y = '0; pix_de = 1'b0;
        hsync_in = 1'b0; vsync_in = 1'b0;
        wr_en = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0; clr = 1'b0;
        cursor_row = 4'd15;
        test_reset();
        test_write_commit();
        test_no_commit();
        test_collision();
        test_invalid();
        test_edges();
        test_back_to_back();
        test_cursor();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
